// File: rtl/ifetch_unit_if.sv
// Bundle of the fetch stage's bus signals: the instruction-memory read port, the
// redirect input from execute and the valid/ready instruction stream to decode.
//   master : view of the fetch unit (drives imem_req/addr and the if_* head)
//   slave  : view of the environment (memory, execute and decode side)
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [5:0]  if_opcode;
  logic [5:0]  if_funct;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output if_valid, if_pc, if_instr, if_opcode, if_funct,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  if_valid, if_pc, if_instr, if_opcode, if_funct,
    output if_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage. Owns the PC, issues one instruction-memory read at a
// time and buffers returned words in a DEPTH-entry FIFO whose head is offered to
// decode with opcode/funct pre-split. A redirect flushes the FIFO, reloads the PC
// and discards any read still in flight.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus_io : ifetch_unit_if.master (imem read port, redirect, decode stream)
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic           clk,
  input logic           rst_n,
  ifetch_unit_if.master bus_io
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     fifo_pc_q    [DEPTH];
  logic [31:0]     fifo_instr_q [DEPTH];

  logic push, pop, fifo_full, head_valid;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (32'(p) == DEPTH - 1) return '0;
    return p + PtrW'(1);
  endfunction

  assign fifo_full  = (cnt_q == CntW'(DEPTH));
  assign head_valid = (cnt_q != '0);
  assign pop        = head_valid & bus_io.if_ready;

  // Request FSM. Issue only when a slot is guaranteed for the response, so a
  // push can never overflow with a single read outstanding.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_full && !bus_io.redirect) state_d = StReq;
      end
      StReq: begin
        // The read has already gone out; a redirect now must discard its data.
        state_d = bus_io.redirect ? StDrop : StWait;
      end
      StWait: begin
        if (bus_io.redirect) begin
          state_d = bus_io.imem_rvalid ? StIdle : StDrop;
        end else if (bus_io.imem_rvalid) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (bus_io.imem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // PC and FIFO bookkeeping. A redirect wins over everything; a pop in the same
  // cycle still delivers the head, the remaining entries are simply dropped.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (bus_io.redirect) begin
      pc_d     = bus_io.redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: contents are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= pc_q;
      fifo_instr_q[wr_ptr_q] <= bus_io.imem_rdata;
    end
  end

  assign bus_io.imem_req  = (state_q == StReq);
  assign bus_io.imem_addr = (state_q == StReq) ? pc_q : '0;

  // Empty FIFO presents an all-zero word (NOP) to decode.
  assign bus_io.if_valid  = head_valid;
  assign bus_io.if_pc     = head_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign bus_io.if_instr  = head_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign bus_io.if_opcode = bus_io.if_instr[31:26];
  assign bus_io.if_funct  = bus_io.if_instr[5:0];

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ifetch_unit_if bus ();

  ifetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  bit          mem_abort = 1'b0;
  bit          seen_bad = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C22_0004;
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return 32'hA500_0000 | a;
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ready_pulse(input int n);
    bus.if_ready = 1'b1;
    tick(n);
    bus.if_ready = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.imem_req) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wait_req: no imem_req within %0d cycles", budget);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_imem_req"}, {31'b0, bus.imem_req}, 32'h0);
    chk({tag, "_imem_addr"}, bus.imem_addr, 32'h0);
    chk({tag, "_if_valid"}, {31'b0, bus.if_valid}, 32'h0);
    chk({tag, "_if_pc"}, bus.if_pc, 32'h0);
    chk({tag, "_if_instr"}, bus.if_instr, 32'h0);
    chk({tag, "_if_opcode"}, {26'b0, bus.if_opcode}, 32'h0);
    chk({tag, "_if_funct"}, {26'b0, bus.if_funct}, 32'h0);
  endtask

  // Memory model: one response per request after 'lat' cycles; checks each
  // request address against the expected-address queue.
  initial begin
    logic [31:0] a;
    bit aborted;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && !bus.imem_req) chk("imem_addr_idle", bus.imem_addr, 32'h0);
      if (rst_n && bus.imem_req) begin
        a = bus.imem_addr;
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL imem_req_unexpected: got addr %h expected no request", a);
        end else begin
          chk("imem_addr", a, addr_q.pop_front());
        end
        aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(posedge clk);
          if (mem_abort) begin
            aborted = 1'b1;
            break;
          end
        end
        if (aborted) begin
          mem_abort = 1'b0;
        end else begin
          #1;
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(a);
          @(posedge clk);
          #1;
          bus.imem_rvalid = 1'b0;
          bus.imem_rdata  = '0;
        end
      end
    end
  end

  // Scoreboard monitor: compares every accepted head against the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.if_valid && bus.if_instr == 32'hDEAD_BEEF) seen_bad = 1'b1;
    if (rst_n && bus.if_valid && bus.if_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head_unexpected: got pc %h instr %h expected none",
                 bus.if_pc, bus.if_instr);
      end else begin
        e = exp_q.pop_front();
        chk("head_pc", bus.if_pc, e.pc);
        chk("head_instr", bus.if_instr, e.instr);
        chk("head_opcode", {26'b0, bus.if_opcode}, {26'b0, e.instr[31:26]});
        chk("head_funct", {26'b0, bus.if_funct}, {26'b0, e.instr[5:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // Reset values.
    tick(2);
    @(negedge clk);
    chk_all_zero("reset");

    // First fetch from RESET_PC, then fill with if_ready low: exactly two reads.
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(12);
    @(negedge clk);
    chk("first_valid", {31'b0, bus.if_valid}, 32'h1);
    chk("first_pc", bus.if_pc, 32'h0);
    chk("first_opcode", {26'b0, bus.if_opcode}, 32'h23);
    chk("first_funct", {26'b0, bus.if_funct}, 32'h04);
    chk("full_no_req", {31'b0, bus.imem_req}, 32'h0);
    tick(1);

    // Drain both heads; fetching resumes at 8.
    exp_q.push_back(mk(32'h0, 32'h8C22_0004));
    exp_q.push_back(mk(32'h4, 32'hA500_0004));
    addr_q.push_back(32'h8);
    addr_q.push_back(32'hC);
    ready_pulse(2);
    tick(12);

    // Redirect during WAIT; the late 0xDEADBEEF response must be discarded.
    lat = 4;
    exp_q.push_back(mk(32'h8, 32'hA500_0008));
    addr_q.push_back(32'h10);
    addr_q.push_back(32'h100);
    addr_q.push_back(32'h104);
    ready_pulse(1);
    wait_req(10);
    @(posedge clk);
    #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    tick(1);
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("redir_wait_valid", {31'b0, bus.if_valid}, 32'h0);
    tick(25);
    exp_q.push_back(mk(32'h100, 32'hA500_0100));
    exp_q.push_back(mk(32'h104, 32'hA500_0104));
    addr_q.push_back(32'h108);
    addr_q.push_back(32'h10C);
    ready_pulse(2);
    tick(25);

    // Redirect coincident with rvalid: no DROP cycle, req two cycles later.
    lat = 1;
    exp_q.push_back(mk(32'h108, 32'hA500_0108));
    addr_q.push_back(32'h110);
    addr_q.push_back(32'h200);
    addr_q.push_back(32'h204);
    ready_pulse(1);
    wait_req(10);
    @(posedge clk);
    #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    tick(1);
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("redir_rv_idle_req", {31'b0, bus.imem_req}, 32'h0);
    chk("redir_rv_valid", {31'b0, bus.if_valid}, 32'h0);
    @(negedge clk);
    chk("redir_rv_req", {31'b0, bus.imem_req}, 32'h1);
    chk("redir_rv_addr", bus.imem_addr, 32'h200);
    tick(1);
    tick(12);

    // Redirect with a simultaneous pop on a full FIFO.
    exp_q.push_back(mk(32'h200, 32'hA500_0200));
    addr_q.push_back(32'h300);
    addr_q.push_back(32'h304);
    bus.if_ready    = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    tick(1);
    bus.if_ready = 1'b0;
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("redir_pop_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("redir_pop_instr", bus.if_instr, 32'h0);
    chk("redir_pop_pc", bus.if_pc, 32'h0);
    tick(1);
    tick(12);

    // Asynchronous reset in the middle of WAIT.
    lat = 5;
    exp_q.push_back(mk(32'h300, 32'hA500_0300));
    addr_q.push_back(32'h308);
    ready_pulse(1);
    wait_req(10);
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    mem_abort = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick(3);
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    rst_n = 1'b1;
    tick(30);
    exp_q.push_back(mk(32'h0, 32'h8C22_0004));
    exp_q.push_back(mk(32'h4, 32'hA500_0004));
    addr_q.push_back(32'h8);
    addr_q.push_back(32'hC);
    ready_pulse(2);
    tick(30);

    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("addr_q_drained", 32'(addr_q.size()), 32'h0);
    chk("deadbeef_never_seen", {31'b0, seen_bad}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage. It sits directly upstream of the main decoder and the ALU control decoder.
- Owns the PC and issues one instruction-memory read at a time. Returned words are buffered in a small FIFO.
- The FIFO head is presented to decode as valid/ready with opcode/funct pre-split. Branch/jump redirects from execute flush the FIFO and discard any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- DEPTH, 2, instruction FIFO entries; power of 2, >=1.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  one-cycle read request pulse
- imem_addr  out  32  read address, valid while imem_req=1
- imem_rvalid  in  1  read data valid; exactly one per request, >=1 cycle after imem_req
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- redirect  in  1  branch/jump taken; flush and reload PC
- redirect_pc  in  32  new PC, sampled when redirect=1
- if_valid  out  1  FIFO head valid
- if_ready  in  1  decode accepts head this cycle
- if_pc  out  32  PC of head instruction
- if_instr  out  32  head instruction word
- if_opcode  out  6  if_instr[31:26], feeds the decoder OpCode input
- if_funct  out  6  if_instr[5:0], feeds the ALU control Funct input

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, FIFO count=0. Outputs: imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0, if_opcode=0, if_funct=0.
- FSM states: IDLE (nothing outstanding), REQ (issuing), WAIT (outstanding, keep), DROP (outstanding, discard).
- imem_req=1 only in REQ, with imem_addr=pc. imem_req and imem_addr are decoded from registered state only; imem_addr=0 outside REQ.
- IDLE: if count<DEPTH and !redirect -> REQ.
- REQ: if redirect -> DROP, else -> WAIT. The request has already issued, so its response must be discarded on redirect.
- WAIT, imem_rvalid=1 and !redirect: push {pc, imem_rdata}, pc<=pc+4 (mod 2^32), -> IDLE.
- WAIT, redirect=1: flush FIFO, pc<=redirect_pc. Go to IDLE if imem_rvalid is in the same cycle (that data is discarded), else DROP.
- DROP: imem_rvalid -> IDLE, data discarded, pc unchanged.
- Redirect in any state: flush FIFO, pc<=redirect_pc. In DROP, stay in DROP until rvalid.
- Throughput: at most one outstanding read. Minimum 3 cycles per instruction (IDLE, REQ, WAIT with rvalid on first WAIT cycle).
- FIFO:
  - if_valid = (count!=0).
  - Pop when if_valid & if_ready. Push and pop in the same cycle leave count unchanged.
  - Issue is gated on count<DEPTH with a single outstanding read, so a push never overflows.
  - Pointers wrap modulo DEPTH.
  - When count=0, if_pc, if_instr, if_opcode and if_funct are driven 0 (NOP to the decoder).
- Redirect with a simultaneous pop: the popped head counts as delivered; all other entries are dropped. if_valid=0 in the next cycle.
- Reset mid-operation: an in-flight response arriving after rst_n deasserts is not tracked. The memory side must also be reset.
- if_opcode and if_funct are pure slices of if_instr, with no extra latency.

Test Plan:
- Reset release, memory returns 32'h8C22_0004 one cycle after req -> imem_addr=0 on first req; if_valid=1 with if_pc=0, if_opcode=6'b100011, if_funct=6'b000100; next req has addr 4.
- if_ready=0 throughout, DEPTH=2 -> exactly two requests (addr 0, 4), then imem_req stays 0. Raise if_ready -> heads at pc 0 then 4, then fetching resumes at 8.
- Redirect to 32'h0000_0100 while in WAIT, rvalid 3 cycles later with 32'hDEAD_BEEF -> word never appears on if_instr; next req addr=0x100.
- Redirect in the same cycle as rvalid -> data dropped, FSM to IDLE, next req addr=redirect_pc, no DROP cycle.
- Redirect while FIFO holds 2 entries and if_ready=1 -> head consumed that cycle, if_valid=0 next cycle, if_instr=0.
- Assert rst_n=0 asynchronously mid-WAIT -> all outputs 0 immediately; after release, first req addr=RESET_PC.
